// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined signed adder/subtractor, S = A + B (k=0) or A - B (k=1),
// on N-bit two's-complement operands. The carry chain is cut into SEG-bit
// segments, one segment resolved per pipeline stage (STAGES = N/SEG), so a new
// operation can be accepted every cycle. A valid/ready handshake gives
// backpressure; every stage register advances together on en.
//
// Parameters:
//   N    operand/result width (multiple of SEG)
//   SEG  segment width per stage
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand presented          in_ready   pipeline can accept
//   a, b       signed operands            k          0 = add, 1 = subtract
//   out_valid  result available           out_ready  consumer accepts result
//   s          registered result          ovf        signed overflow of s
//
// Optional feature: define ADD_SUB_SAT_EN to clamp s to the most positive /
// most negative value when ovf is set (ovf is still reported).

module add_sub_pipe #(
    parameter int N   = 8,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         k,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         ovf
);

    localparam int STAGES = N / SEG;

    logic              en;

    // Per-stage state: valid bit, partial sum, carry into the next segment,
    // and the delayed A / B' operands (B' already inverted for subtract).
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] carry_reg;
    logic [STAGES-1:0] carry_next;
    logic [N-1:0]      a_reg     [STAGES];
    logic [N-1:0]      a_next    [STAGES];
    logic [N-1:0]      b_reg     [STAGES];
    logic [N-1:0]      b_next    [STAGES];
    logic [N-1:0]      sum_reg   [STAGES];
    logic [N-1:0]      sum_next  [STAGES];
    logic              ovf_reg;
    logic              ovf_next;

    // Per-iteration working values of the stage loop below.
    logic [N-1:0]      a_in;
    logic [N-1:0]      b_in;
    logic [N-1:0]      s_in;
    logic              c_in;
    logic              v_in;
    logic [SEG:0]      seg_sum;
    int                prev;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign out_valid = valid_reg[STAGES-1];
    assign s         = sum_reg[STAGES-1];
    assign ovf       = ovf_reg;

    always_comb begin
        a_in     = '0;
        b_in     = '0;
        s_in     = '0;
        c_in     = 1'b0;
        v_in     = 1'b0;
        seg_sum  = '0;
        prev     = 0;
        ovf_next = 1'b0;
        for (int j = 0; j < STAGES; j++) begin
            // prev is clamped so the j = 0 iteration never indexes below 0.
            prev = (j > 0) ? j - 1 : 0;
            if (j == 0) begin
                a_in = a;
                b_in = k ? ~b : b;
                c_in = k;              // +1 completes the two's-complement negate
                s_in = '0;
                v_in = in_valid & in_ready;
            end else begin
                a_in = a_reg[prev];
                b_in = b_reg[prev];
                c_in = carry_reg[prev];
                s_in = sum_reg[prev];
                v_in = valid_reg[prev];
            end
            seg_sum = {1'b0, a_in[j*SEG +: SEG]} + {1'b0, b_in[j*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_in};
            sum_next[j]              = s_in;
            sum_next[j][j*SEG +: SEG] = seg_sum[SEG-1:0];
            carry_next[j]            = seg_sum[SEG];
            valid_next[j]            = v_in;
            a_next[j]                = a_in;
            b_next[j]                = b_in;
            if (j == STAGES - 1) begin
                // Carry-in(MSB) xor carry-out(MSB) reduces to: effective operands
                // share a sign and the result sign differs from it.
                ovf_next = (a_in[N-1] ~^ b_in[N-1]) & (sum_next[j][N-1] ^ a_in[N-1]);
`ifdef ADD_SUB_SAT_EN
                // On overflow both operands share a's sign, which picks the rail.
                if (ovf_next) begin
                    sum_next[j] = a_in[N-1] ? {1'b1, {(N-1){1'b0}}}
                                            : {1'b0, {(N-1){1'b1}}};
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            carry_reg <= '0;
            ovf_reg   <= 1'b0;
            for (int j = 0; j < STAGES; j++) begin
                a_reg[j]   <= '0;
                b_reg[j]   <= '0;
                sum_reg[j] <= '0;
            end
        end else if (en) begin
            valid_reg <= valid_next;
            carry_reg <= carry_next;
            ovf_reg   <= ovf_next;
            for (int j = 0; j < STAGES; j++) begin
                a_reg[j]   <= a_next[j];
                b_reg[j]   <= b_next[j];
                sum_reg[j] <= sum_next[j];
            end
        end
    end

    // The last stage's operand copies and carry-out have no consumer.
    logic unused_bits;
    assign unused_bits = ^{carry_reg[STAGES-1], a_reg[STAGES-1], b_reg[STAGES-1]};

endmodule

// File: tb/tb_add_sub_pipe.sv
// Testbench for add_sub_pipe: three instances (N=8/SEG=4, N=16/SEG=4,
// N=8/SEG=8). Expected results come from an arithmetic reference model and are
// queued at acceptance, then popped and compared when each DUT hands a result out.

module tb_add_sub_pipe;

    typedef struct {
        logic [15:0] s;
        logic        ovf;
        int          stamp;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   nout [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // Instance 0: N=8, SEG=4
    logic [7:0]  a0 = '0, b0 = '0, s0;
    logic        k0 = 1'b0, iv0 = 1'b0, ir0, ov0, or0 = 1'b1, f0;
    // Instance 1: N=16, SEG=4
    logic [15:0] a1 = '0, b1 = '0, s1;
    logic        k1 = 1'b0, iv1 = 1'b0, ir1, ov1, or1 = 1'b1, f1;
    // Instance 2: N=8, SEG=8
    logic [7:0]  a2 = '0, b2 = '0, s2;
    logic        k2 = 1'b0, iv2 = 1'b0, ir2, ov2, or2 = 1'b1, f2;

    add_sub_pipe #(.N(8), .SEG(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .k(k0),
        .out_valid(ov0), .out_ready(or0), .s(s0), .ovf(f0));
    add_sub_pipe #(.N(16), .SEG(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .k(k1),
        .out_valid(ov1), .out_ready(or1), .s(s1), .ovf(f1));
    add_sub_pipe #(.N(8), .SEG(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .k(k2),
        .out_valid(ov2), .out_ready(or2), .s(s2), .ovf(f2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, s}: exact integer arithmetic, then range test and wrap/clamp.
    function automatic logic [16:0] ref_model(input int n, input logic [15:0] av,
                                              input logic [15:0] bv, input bit kv);
        longint lim, sa, sb, r;
        logic   ov;
        lim = longint'(1) << (n - 1);
        sa  = longint'(av) & (2 * lim - 1);
        sb  = longint'(bv) & (2 * lim - 1);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        r  = kv ? sa - sb : sa + sb;
        ov = (r >= lim) || (r < -lim);
`ifdef ADD_SUB_SAT_EN
        if (r >= lim) r = lim - 1;
        else if (r < -lim) r = -lim;
`endif
        return {ov, 16'(r & (2 * lim - 1))};
    endfunction

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic int lat_of(input int sel);
        case (sel)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    // Present one operation; wait (bounded) for acceptance. Called and returns at posedge+#1.
    task automatic drive(input int sel, input logic [15:0] av, input logic [15:0] bv,
                         input bit kv, input bit lat);
        bit          done = 1'b0;
        logic [16:0] m;
        exp_t        e;
        int          n = (sel == 1) ? 16 : 8;
        case (sel)
            0:       begin a0 = av[7:0]; b0 = bv[7:0]; k0 = kv; iv0 = 1'b1; end
            1:       begin a1 = av;      b1 = bv;      k1 = kv; iv1 = 1'b1; end
            default: begin a2 = av[7:0]; b2 = bv[7:0]; k2 = kv; iv2 = 1'b1; end
        endcase
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ready_of(sel)) begin
                m       = ref_model(n, av, bv, kv);
                e.s     = m[15:0];
                e.ovf   = m[16];
                e.stamp = cyc;
                e.lat   = lat;
                case (sel)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("dut%0d accept", sel), 32'(done), 1);
    endtask

    task automatic idle(input int sel);
        case (sel)
            0:       iv0 = 1'b0;
            1:       iv1 = 1'b0;
            default: iv2 = 1'b0;
        endcase
    endtask

    task automatic wait_drain(input int sel);
        for (int i = 0; i < 100 && qsize(sel) != 0; i++) @(negedge clk);
        check($sformatf("dut%0d drain", sel), 32'(qsize(sel)), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic take(input int sel, input logic [15:0] sv, input logic ov);
        exp_t e;
        int   sz = qsize(sel);
        if (sz == 0) begin
            check($sformatf("dut%0d unexpected output", sel), 32'(sz), 1);
        end else begin
            case (sel)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            nout[sel]++;
            $display("dut%0d out s=%h ovf=%0d exp s=%h ovf=%0d", sel, sv, ov, e.s, e.ovf);
            check($sformatf("dut%0d s", sel), 32'(sv), 32'(e.s));
            check($sformatf("dut%0d ovf", sel), 32'(ov), 32'(e.ovf));
            if (e.lat) check($sformatf("dut%0d latency", sel), 32'(cyc - e.stamp), 32'(lat_of(sel)));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ov0 && or0) take(0, {8'h00, s0}, f0);
            if (ov1 && or1) take(1, s1, f1);
            if (ov2 && or2) take(2, {8'h00, s2}, f2);
        end
    end

    task automatic stream(input int sel);
        int          n0 = nout[sel];
        int          c0;
        logic [15:0] ra, rb;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive(sel, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
        end
        check($sformatf("dut%0d stream rate", sel), 32'(cyc - c0), 16);
        idle(sel);
        wait_drain(sel);
        check($sformatf("dut%0d stream count", sel), 32'(nout[sel] - n0), 16);
    endtask

    logic [7:0] held;

    initial begin
        logic [23:0] dir [8];
        logic [23:0] t;
        dir = '{24'h050300, 24'h050301, 24'h7F0100, 24'h800101,
                24'h0F0100, 24'h000101, 24'h008001, 24'hFF8001};
        for (int i = 0; i < 3; i++) nout[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(ov0), 0);
        check("rst s", 32'(s0), 0);
        check("rst ovf", 32'(f0), 0);
        check("rst in_ready", 32'(ir0), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst out_valid", 32'(ov0), 0);

        // Directed cases, each from an empty pipeline with latency checked.
        for (int i = 0; i < 8; i++) begin
            t = dir[i];
            drive(0, {8'h00, t[23:16]}, {8'h00, t[15:8]}, t[0], 1'b1);
            idle(0);
            wait_drain(0);
        end

        stream(0);

        // Backpressure: stall the consumer with items queued inside the pipe.
        or0 = 1'b0;
        fork
            begin
                drive(0, 16'h0011, 16'h0022, 1'b0, 1'b0);
                drive(0, 16'h0070, 16'h0020, 1'b0, 1'b0);
                drive(0, 16'h0003, 16'h0009, 1'b1, 1'b0);
                idle(0);
            end
            begin
                for (int i = 0; i < 20 && !ov0; i++) @(negedge clk);
                check("bp out_valid", 32'(ov0), 1);
                held = s0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp in_ready", 32'(ir0), 0);
                    check("bp s stable", 32'(s0), 32'(held));
                end
                @(posedge clk);
                #1;
                or0 = 1'b1;
            end
        join
        wait_drain(0);

        // Reset with two items in flight discards them.
        drive(0, 16'h0001, 16'h0002, 1'b0, 1'b0);
        drive(0, 16'h0003, 16'h0004, 1'b0, 1'b0);
        idle(0);
        rst = 1'b1;
        #1;
        check("mid-rst out_valid", 32'(ov0), 0);
        check("mid-rst s", 32'(s0), 0);
        check("mid-rst ovf", 32'(f0), 0);
        check("mid-rst in_ready", 32'(ir0), 1);
        q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 16'h0012, 16'h0034, 1'b0, 1'b1);
        idle(0);
        wait_drain(0);

        stream(1);
        stream(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
